imu_sensor_i2c_reg_bank: RTL and testbench

Parametrised register bank between the opencores-derived I2C slave byte engine and the IMU sensor emulator core. It exposes NUM_RO read-only sensor bytes, NUM_RW host-writable control bytes and one status byte on a single 8-bit address space. It adds a coherent snapshot of sensor data per read transaction, a sticky data-ready/overrun status, and per-register write-event pulses. Unmapped writes are discarded.

---
 rtl/imu_sensor_i2c_reg_bank_pkg.sv | 13 +
 rtl/imu_sensor_i2c_reg_bank_if.sv | 17 +
 rtl/imu_sensor_i2c_reg_bank_status.sv | 43 ++++
 rtl/imu_sensor_i2c_reg_bank.sv | 86 ++++++++
 tb/tb_imu_sensor_i2c_reg_bank.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/imu_sensor_i2c_reg_bank_pkg.sv
// Shared constants for the IMU register bank: bus widths, status bit
// positions and the value returned for unmapped reads.
package imu_sensor_reg_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 8;

  localparam int STAT_NEWDATA = 0;
  localparam int STAT_OVR     = 1;

  localparam logic [DATA_W-1:0] UNMAPPED_VALUE = 8'h00;

endpackage

// File: rtl/imu_sensor_i2c_reg_bank_if.sv
// Byte-level register bus between the I2C slave engine (master side)
// and the register bank (slave side).
interface imu_sensor_i2c_reg_bank_if;
  import imu_sensor_reg_pkg::*;

  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] dataIn;
  logic              writeEn;
  logic              snapReq;
  logic [DATA_W-1:0] dataOut;

  modport master (output addr, output dataIn, output writeEn, output snapReq,
                  input dataOut);
  modport slave  (input addr, input dataIn, input writeEn, input snapReq,
                  output dataOut);

endinterface

// File: rtl/imu_sensor_i2c_reg_bank_status.sv
// Sticky newData/overrun flags; a fresh sample always wins over a clear
// arriving in the same cycle.
module imu_sensor_reg_status
  import imu_sensor_reg_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              data_valid,
  input  logic              snap_req,
  input  logic              clr_ovr,
  output logic [DATA_W-1:0] status
);

  logic new_data_q, new_data_d;
  logic ovr_q, ovr_d;

  // Clears are applied first so the later set assignments take priority.
  always_comb begin
    new_data_d = new_data_q;
    ovr_d      = ovr_q;
    if (clr_ovr) ovr_d = 1'b0;
    if (data_valid && new_data_q && !snap_req) ovr_d = 1'b1;
    if (snap_req) new_data_d = 1'b0;
    if (data_valid) new_data_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      new_data_q <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      new_data_q <= new_data_d;
      ovr_q      <= ovr_d;
    end
  end

  always_comb begin
    status               = '0;
    status[STAT_NEWDATA] = new_data_q;
    status[STAT_OVR]     = ovr_q;
  end

endmodule

// File: rtl/imu_sensor_i2c_reg_bank.sv
// Register bank for the IMU sensor emulator: RO sensor bytes, RW control
// bytes and a status byte. Define IMU_REG_SNAPSHOT_EN to add the shadow bank.
module imu_sensor_i2c_reg_bank
  import imu_sensor_reg_pkg::*;
#(
  parameter int                  NUM_RO  = 21,
  parameter int                  NUM_RW  = 4,
  parameter logic [8*NUM_RW-1:0] RW_INIT = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  imu_sensor_i2c_reg_bank_if.slave bus,
  input  logic [8*NUM_RO-1:0]      roData,
  input  logic                     dataValid,
  output logic [8*NUM_RW-1:0]      rwData,
  output logic [NUM_RW-1:0]        rwWrPulse,
  output logic                     newData
);

  localparam int STATUS_ADDR = NUM_RO + NUM_RW;

  logic [8*NUM_RO-1:0] ro_src;
  logic [DATA_W-1:0]   status;
  logic [DATA_W-1:0]   read_next;
  logic [NUM_RW-1:0]   rw_hit;
  logic                status_hit;

`ifdef IMU_REG_SNAPSHOT_EN
  logic [8*NUM_RO-1:0] shadow;

  always_ff @(posedge clk) begin
    if (rst) shadow <= '0;
    else if (bus.snapReq) shadow <= roData;
  end

  assign ro_src = shadow;
`else
  assign ro_src = roData;
`endif

  assign status_hit = bus.writeEn && (bus.addr == ADDR_W'(STATUS_ADDR));

  imu_sensor_reg_status u_status (
    .clk        (clk),
    .rst        (rst),
    .data_valid (dataValid),
    .snap_req   (bus.snapReq),
    .clr_ovr    (status_hit && bus.dataIn[STAT_OVR]),
    .status     (status)
  );

  assign newData = status[STAT_NEWDATA];

  always_comb begin
    rw_hit = '0;
    for (int i = 0; i < NUM_RW; i++)
      rw_hit[i] = bus.writeEn && (bus.addr == ADDR_W'(NUM_RO + i));
  end

  // Pulses mirror the write hit one cycle later, so reset drops any pending one.
  always_ff @(posedge clk) begin
    if (rst) begin
      rwData    <= RW_INIT;
      rwWrPulse <= '0;
    end else begin
      rwWrPulse <= rw_hit;
      for (int i = 0; i < NUM_RW; i++)
        if (rw_hit[i]) rwData[8*i +: 8] <= bus.dataIn;
    end
  end

  always_comb begin
    read_next = UNMAPPED_VALUE;
    for (int i = 0; i < NUM_RO; i++)
      if (bus.addr == ADDR_W'(i)) read_next = ro_src[8*i +: 8];
    for (int i = 0; i < NUM_RW; i++)
      if (bus.addr == ADDR_W'(NUM_RO + i)) read_next = rwData[8*i +: 8];
    if (bus.addr == ADDR_W'(STATUS_ADDR)) read_next = status;
  end

  always_ff @(posedge clk) begin
    if (rst) bus.dataOut <= '0;
    else     bus.dataOut <= read_next;
  end

endmodule

// File: tb/tb_imu_sensor_i2c_reg_bank.sv
// Directed self-checking bench for imu_sensor_i2c_reg_bank with
// RW_INIT = 0x11223344; expectations follow IMU_REG_SNAPSHOT_EN.
module tb_imu_sensor_i2c_reg_bank;

  localparam int NUM_RO = 21;
  localparam int NUM_RW = 4;
  localparam logic [31:0] RW_INIT = 32'h1122_3344;
  localparam logic [7:0] STAT = 8'd25;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [8*NUM_RO-1:0] roData = '0;
  logic dataValid = 1'b0;
  logic [8*NUM_RW-1:0] rwData;
  logic [NUM_RW-1:0] rwWrPulse;
  logic newData;

  int checks = 0;
  int errors = 0;

  imu_sensor_i2c_reg_bank_if bus ();

  imu_sensor_i2c_reg_bank #(
    .NUM_RO  (NUM_RO),
    .NUM_RW  (NUM_RW),
    .RW_INIT (RW_INIT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .roData    (roData),
    .dataValid (dataValid),
    .rwData    (rwData),
    .rwWrPulse (rwWrPulse),
    .newData   (newData)
  );

  always #5 clk = ~clk;

  // One clock: drive, pass the edge, settle, then drop the strobes.
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] d,
                               input logic we, input logic snap, input logic dv);
    bus.addr    = a;
    bus.dataIn  = d;
    bus.writeEn = we;
    bus.snapReq = snap;
    dataValid   = dv;
    @(posedge clk);
    #1;
    bus.writeEn = 1'b0;
    bus.snapReq = 1'b0;
    dataValid   = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  initial begin
    bus.addr = 8'h00; bus.dataIn = 8'h00; bus.writeEn = 1'b0; bus.snapReq = 1'b0;

    // Reset
    rst = 1'b1;
    applyStimulus(8'd0, 8'h00, 1'b0, 1'b0, 1'b0);
    applyStimulus(8'd0, 8'h00, 1'b0, 1'b0, 1'b0);
    checkOutput("reset_rwData", rwData, 32'h1122_3344);
    checkOutput("reset_dataOut", {24'd0, bus.dataOut}, 32'h00);
    checkOutput("reset_pulse", {28'd0, rwWrPulse}, 32'h0);
    checkOutput("reset_newData", {31'd0, newData}, 32'h0);
    rst = 1'b0;
    applyStimulus(STAT, 8'h00, 1'b0, 1'b0, 1'b0);
    checkOutput("reset_status", {24'd0, bus.dataOut}, 32'h00);
    applyStimulus(8'd23, 8'h00, 1'b0, 1'b0, 1'b0);
    checkOutput("reset_rw2_read", {24'd0, bus.dataOut}, 32'h22);

    // Write and read back
    applyStimulus(8'd23, 8'hA5, 1'b1, 1'b0, 1'b0);
    checkOutput("wr_rwData", rwData, 32'h11A5_3344);
    checkOutput("wr_pulse", {28'd0, rwWrPulse}, 32'h4);
    applyStimulus(8'd23, 8'h00, 1'b0, 1'b0, 1'b0);
    checkOutput("wr_readback", {24'd0, bus.dataOut}, 32'hA5);
    checkOutput("wr_pulse_gone", {28'd0, rwWrPulse}, 32'h0);
    applyStimulus(8'h03, 8'hFF, 1'b1, 1'b0, 1'b0);
    checkOutput("ro_wr_pulse", {28'd0, rwWrPulse}, 32'h0);
    applyStimulus(8'hF0, 8'hFF, 1'b1, 1'b0, 1'b0);
    checkOutput("unmap_wr_pulse", {28'd0, rwWrPulse}, 32'h0);
    checkOutput("unmap_wr_rwData", rwData, 32'h11A5_3344);
    applyStimulus(8'h03, 8'h00, 1'b0, 1'b0, 1'b0);
    checkOutput("ro_wr_read", {24'd0, bus.dataOut}, 32'h00);
    applyStimulus(STAT, 8'h00, 1'b0, 1'b0, 1'b0);
    checkOutput("unmap_wr_status", {24'd0, bus.dataOut}, 32'h00);
    applyStimulus(8'hF0, 8'h00, 1'b0, 1'b0, 1'b0);
    checkOutput("unmap_read", {24'd0, bus.dataOut}, 32'h00);

    // Snapshot coherence
    roData[7:0] = 8'h10;
    applyStimulus(8'd0, 8'h00, 1'b0, 1'b1, 1'b0);
`ifdef IMU_REG_SNAPSHOT_EN
    checkOutput("snap_pre_read", {24'd0, bus.dataOut}, 32'h00);
`else
    checkOutput("snap_pre_read", {24'd0, bus.dataOut}, 32'h10);
`endif
    roData[7:0] = 8'h20;
    applyStimulus(8'd0, 8'h00, 1'b0, 1'b0, 1'b0);
`ifdef IMU_REG_SNAPSHOT_EN
    checkOutput("snap_first_read", {24'd0, bus.dataOut}, 32'h10);
`else
    checkOutput("snap_first_read", {24'd0, bus.dataOut}, 32'h20);
`endif
    applyStimulus(8'd0, 8'h00, 1'b0, 1'b1, 1'b0);
    applyStimulus(8'd0, 8'h00, 1'b0, 1'b0, 1'b0);
    checkOutput("snap_second_read", {24'd0, bus.dataOut}, 32'h20);

    // Status flags
    applyStimulus(8'd0, 8'h00, 1'b0, 1'b0, 1'b1);
    checkOutput("dv1_newData", {31'd0, newData}, 32'h1);
    applyStimulus(8'd0, 8'h00, 1'b0, 1'b0, 1'b1);
    applyStimulus(STAT, 8'h00, 1'b0, 1'b0, 1'b0);
    checkOutput("status_ovr", {24'd0, bus.dataOut}, 32'h03);
    applyStimulus(STAT, 8'h00, 1'b0, 1'b1, 1'b0);
    checkOutput("status_snap_cycle", {24'd0, bus.dataOut}, 32'h03);
    applyStimulus(STAT, 8'h00, 1'b0, 1'b0, 1'b0);
    checkOutput("status_after_snap", {24'd0, bus.dataOut}, 32'h02);
    checkOutput("newData_after_snap", {31'd0, newData}, 32'h0);
    applyStimulus(STAT, 8'h02, 1'b1, 1'b0, 1'b0);
    applyStimulus(STAT, 8'h00, 1'b0, 1'b0, 1'b0);
    checkOutput("status_w1c", {24'd0, bus.dataOut}, 32'h00);

    // Simultaneous dataValid and snapReq with newData=0
    roData[15:0] = 16'h4433;
    applyStimulus(8'd0, 8'h00, 1'b0, 1'b1, 1'b1);
    applyStimulus(STAT, 8'h00, 1'b0, 1'b0, 1'b0);
    checkOutput("sim_dv_snap_status", {24'd0, bus.dataOut}, 32'h01);
    applyStimulus(8'd0, 8'h00, 1'b0, 1'b0, 1'b0);
    checkOutput("sim_shadow_b0", {24'd0, bus.dataOut}, 32'h33);
    applyStimulus(8'd1, 8'h00, 1'b0, 1'b0, 1'b0);
    checkOutput("sim_shadow_b1", {24'd0, bus.dataOut}, 32'h44);

    // dataValid with W1C of ovr while newData=1: set wins
    applyStimulus(STAT, 8'h00, 1'b0, 1'b0, 1'b1);
    applyStimulus(STAT, 8'h00, 1'b0, 1'b0, 1'b0);
    checkOutput("ovr_set", {24'd0, bus.dataOut}, 32'h03);
    applyStimulus(STAT, 8'h02, 1'b1, 1'b0, 1'b1);
    applyStimulus(STAT, 8'h00, 1'b0, 1'b0, 1'b0);
    checkOutput("ovr_set_wins", {24'd0, bus.dataOut}, 32'h03);
    applyStimulus(STAT, 8'h01, 1'b1, 1'b0, 1'b0);
    applyStimulus(STAT, 8'h00, 1'b0, 1'b0, 1'b0);
    checkOutput("w1c_bit0_ignored", {24'd0, bus.dataOut}, 32'h03);

    // Back-to-back writes
    applyStimulus(8'd21, 8'h5A, 1'b1, 1'b0, 1'b0);
    checkOutput("b2b_pulse0", {28'd0, rwWrPulse}, 32'h1);
    applyStimulus(8'd22, 8'h6B, 1'b1, 1'b0, 1'b0);
    checkOutput("b2b_pulse1", {28'd0, rwWrPulse}, 32'h2);
    checkOutput("b2b_rwData", rwData, 32'h11A5_6B5A);
    applyStimulus(8'd22, 8'h00, 1'b0, 1'b0, 1'b0);
    checkOutput("b2b_pulse_end", {28'd0, rwWrPulse}, 32'h0);
    checkOutput("b2b_read", {24'd0, bus.dataOut}, 32'h6B);

    // Reset mid-operation
    applyStimulus(8'd24, 8'h77, 1'b1, 1'b0, 1'b0);
    checkOutput("pre_rst_rwData", rwData, 32'h77A5_6B5A);
    checkOutput("pre_rst_pulse", {28'd0, rwWrPulse}, 32'h8);
    rst = 1'b1;
    applyStimulus(8'd24, 8'h00, 1'b0, 1'b0, 1'b0);
    checkOutput("rst_rwData", rwData, 32'h1122_3344);
    checkOutput("rst_pulse", {28'd0, rwWrPulse}, 32'h0);
    checkOutput("rst_newData", {31'd0, newData}, 32'h0);
    checkOutput("rst_dataOut", {24'd0, bus.dataOut}, 32'h00);
    rst = 1'b0;
    applyStimulus(8'd21, 8'h99, 1'b1, 1'b0, 1'b0);
    rst = 1'b1;
    applyStimulus(8'd21, 8'h00, 1'b0, 1'b0, 1'b0);
    checkOutput("rst_after_wr_pulse", {28'd0, rwWrPulse}, 32'h0);
    checkOutput("rst_after_wr_rwData", rwData, 32'h1122_3344);
    rst = 1'b0;
    applyStimulus(STAT, 8'h00, 1'b0, 1'b0, 1'b0);
    checkOutput("rst_status", {24'd0, bus.dataOut}, 32'h00);
    applyStimulus(8'd21, 8'h00, 1'b0, 1'b0, 1'b0);
    checkOutput("rst_rw0_read", {24'd0, bus.dataOut}, 32'h44);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
